// File: rtl/gcd_pkg.sv
// Shared state encodings and default sizing for the GCD operand feeder.
package gcd_pkg;
    localparam int GCD_W_DEFAULT     = 16;
    localparam int GCD_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;
endpackage

// File: rtl/pair_fifo.sv
// Operand-pair FIFO, DEPTH a power of two so pointers wrap naturally.
// Zero-latency head; push ignored when full, pop ignored when empty.
module pair_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_a,
    input  logic [W-1:0]               push_b,
    input  logic                       pop,
    output logic [W-1:0]               head_a,
    output logic [W-1:0]               head_b,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem_a [DEPTH];
    logic [W-1:0]  mem_b [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_a  = mem_a[rd_ptr];
    assign head_b  = mem_b[rd_ptr];

    // Storage is left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_a[wr_ptr] <= push_a;
            mem_b[wr_ptr] <= push_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/gcd_operand_feeder.sv
// Queues operand pairs and hands them to a GCD controller with a one-cycle load strobe.
// Pair into empty FIFO at edge t strobes after edge t+1; in_ready = !full (no write-through); ZERO_FILTER_EN drops (0,0) pairs.
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W_DEFAULT,
    parameter int DEPTH = GCD_DEPTH_DEFAULT
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    input  logic                       input_available,
    output logic                       input_ready,
    output logic [W-1:0]               gcd_a,
    output logic [W-1:0]               gcd_b,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef ZERO_FILTER_EN
    ,output logic [7:0]                drop_cnt
`endif
);
    state_t         state;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    assign in_ready = !fifo_full && !sys_rst;

`ifdef ZERO_FILTER_EN
    logic head_zero;
    assign head_zero = (head_a == '0) && (head_b == '0);
    // A zero pair is discarded in IDLE whether or not the controller is ready.
    assign fifo_pop  = (state == IDLE) && !fifo_empty && (head_zero || input_available);
`else
    assign fifo_pop  = (state == IDLE) && !fifo_empty && input_available;
`endif

    pair_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .push   (in_valid && in_ready),
        .push_a (in_a),
        .push_b (in_b),
        .pop    (fifo_pop),
        .head_a (head_a),
        .head_b (head_b),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            input_ready <= 1'b0;
            gcd_a       <= '0;
            gcd_b       <= '0;
`ifdef ZERO_FILTER_EN
            drop_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
`ifdef ZERO_FILTER_EN
                        if (head_zero) begin
                            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                        end else
`endif
                        if (input_available) begin
                            gcd_a       <= head_a;
                            gcd_b       <= head_b;
                            input_ready <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    input_ready <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // Controller leaving READY proves it has consumed the operands.
                    if (!input_available) state <= IDLE;
                end
                default: begin
                    input_ready <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Self-checking bench for gcd_operand_feeder: directed scenarios plus a randomized stream against a queue model.
module tb_gcd_operand_feeder;
    import gcd_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          input_available;
    logic          input_ready;
    logic [W-1:0]  gcd_a;
    logic [W-1:0]  gcd_b;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef ZERO_FILTER_EN
    logic [7:0]    drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    gcd_operand_feeder #(.W(W), .DEPTH(DEPTH)) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
        .input_available (input_available),
        .input_ready     (input_ready),
        .gcd_a           (gcd_a),
        .gcd_b           (gcd_b),
        .fifo_count      (fifo_count)
`ifdef ZERO_FILTER_EN
        ,.drop_cnt       (drop_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd;
        return W'($urandom_range(1, 65535));
    endfunction

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Bench acts as the GCD controller: become ready, wait for the strobe, then leave READY.
    task automatic issue_one(input logic [W-1:0] ea, input logic [W-1:0] eb, input string name);
        bit seen = 0;
        input_available = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (input_ready) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: strobe timeout, input_ready=%b expected 1", name, input_ready);
        end else begin
            checks++;
            if (gcd_a !== ea || gcd_b !== eb) begin
                errors++;
                $display("FAIL %s: operands got a=%0d b=%0d expected a=%0d b=%0d", name, gcd_a, gcd_b, ea, eb);
            end
        end
        input_available = 1'b0;
        tick();
        checks++;
        if (input_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_width: input_ready=%b expected 0", name, input_ready);
        end
        tick();
    endtask

    task automatic test_reset;
        sys_rst = 1'b1; in_valid = 1'b1; in_a = 16'd5; in_b = 16'd7; input_available = 1'b0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", input_ready); end
        checks++; if (gcd_a !== '0 || gcd_b !== '0) begin errors++; $display("FAIL rst_operands: got %0d/%0d expected 0/0", gcd_a, gcd_b); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", dut.state); end
`ifdef ZERO_FILTER_EN
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", drop_cnt); end
`endif
        in_valid = 1'b0;
        sys_rst  = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single;
        input_available = 1'b1;
        in_valid = 1'b1; in_a = 16'd48; in_b = 16'd18;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept: in_ready=%b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (input_ready !== 1'b0 || fifo_count !== 1) begin errors++; $display("FAIL single_t0: strobe=%b count=%0d expected 0/1", input_ready, fifo_count); end
        tick();
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL single_latency: strobe=%b expected 1", input_ready); end
        checks++; if (gcd_a !== 16'd48 || gcd_b !== 16'd18) begin errors++; $display("FAIL single_operands: got %0d/%0d expected 48/18", gcd_a, gcd_b); end
        input_available = 1'b0;
        tick();
        checks++; if (input_ready !== 1'b0 || fifo_count !== 0) begin errors++; $display("FAIL single_one_cycle: strobe=%b count=%0d expected 0/0", input_ready, fifo_count); end
        tick();
    endtask

    task automatic test_fill;
        qa.delete(); qb.delete();
        input_available = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            qa.push_back(rnd()); qb.push_back(rnd());
            push_pair(qa[i], qb[i]);
        end
        checks++; if (fifo_count !== DEPTH) begin errors++; $display("FAIL fill_count: got %0d expected %0d", fifo_count, DEPTH); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: in_ready=%b expected 0", in_ready); end
        push_pair(16'd777, 16'd555);
        checks++; if (fifo_count !== DEPTH) begin errors++; $display("FAIL fill_reject: count=%0d expected %0d", fifo_count, DEPTH); end
        while (qa.size() > 0) begin
            issue_one(qa[0], qb[0], "fill_order");
            void'(qa.pop_front()); void'(qb.pop_front());
        end
        checks++; if (fifo_count !== 0) begin errors++; $display("FAIL fill_drained: count=%0d expected 0", fifo_count); end
    endtask

    task automatic test_hold;
        logic [W-1:0] a1, b1, a2, b2;
        a1 = rnd(); b1 = rnd(); a2 = rnd(); b2 = rnd();
        input_available = 1'b1;
        in_valid = 1'b1; in_a = a1; in_b = b1;
        tick();
        in_a = a2; in_b = b2;
        tick();
        in_valid = 1'b0;
        checks++; if (input_ready !== 1'b1 || gcd_a !== a1 || gcd_b !== b1) begin
            errors++; $display("FAIL hold_first: strobe=%b a=%0d b=%0d expected 1 %0d %0d", input_ready, gcd_a, gcd_b, a1, b1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (input_ready !== 1'b0 || gcd_a !== a1 || gcd_b !== b1 || fifo_count !== 1) begin
                errors++; $display("FAIL hold_wait: strobe=%b a=%0d count=%0d expected 0 %0d 1", input_ready, gcd_a, fifo_count, a1);
            end
        end
        input_available = 1'b0;
        tick();
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL hold_release: strobe=%b expected 0", input_ready); end
        input_available = 1'b1;
        tick();
        checks++; if (input_ready !== 1'b1 || gcd_a !== a2 || gcd_b !== b2) begin
            errors++; $display("FAIL hold_second: strobe=%b a=%0d b=%0d expected 1 %0d %0d", input_ready, gcd_a, gcd_b, a2, b2);
        end
        input_available = 1'b0;
        tick(); tick();
    endtask

    task automatic test_same_edge;
        logic [W-1:0] a [3];
        logic [W-1:0] b [3];
        for (int i = 0; i < 3; i++) begin a[i] = rnd(); b[i] = rnd(); end
        input_available = 1'b0;
        push_pair(a[0], b[0]);
        push_pair(a[1], b[1]);
        in_valid = 1'b1; in_a = a[2]; in_b = b[2]; input_available = 1'b1;
        tick();
        in_valid = 1'b0; input_available = 1'b0;
        checks++; if (fifo_count !== 2) begin errors++; $display("FAIL same_edge_count: got %0d expected 2", fifo_count); end
        checks++; if (input_ready !== 1'b1 || gcd_a !== a[0]) begin errors++; $display("FAIL same_edge_issue: strobe=%b a=%0d expected 1 %0d", input_ready, gcd_a, a[0]); end
        tick(); tick();
        issue_one(a[1], b[1], "same_edge_2");
        issue_one(a[2], b[2], "same_edge_3");
    endtask

    task automatic test_zero_pair;
`ifdef ZERO_FILTER_EN
        input_available = 1'b0;
        push_pair(16'd0, 16'd0);
        push_pair(16'd9, 16'd6);
        tick();
        checks++; if (drop_cnt !== 8'd1 || fifo_count !== 1) begin errors++; $display("FAIL zero_drop: drop=%0d count=%0d expected 1/1", drop_cnt, fifo_count); end
        issue_one(16'd9, 16'd6, "zero_next");
        for (int i = 0; i < 300; i++) push_pair(16'd0, 16'd0);
        tick(); tick();
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL zero_saturate: drop=%0d expected 255", drop_cnt); end
        checks++; if (fifo_count !== 0) begin errors++; $display("FAIL zero_empty: count=%0d expected 0", fifo_count); end
`else
        input_available = 1'b0;
        push_pair(16'd0, 16'd0);
        issue_one(16'd0, 16'd0, "zero_forward");
`endif
    endtask

    task automatic test_reset_mid;
        input_available = 1'b0;
        for (int i = 0; i < 4; i++) push_pair(rnd(), rnd());
        input_available = 1'b1;
        tick();
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL mid_issue: strobe=%b expected 1", input_ready); end
        tick();
        checks++; if (fifo_count !== 3) begin errors++; $display("FAIL mid_queued: count=%0d expected 3", fifo_count); end
        sys_rst = 1'b1;
        tick();
        checks++; if (fifo_count !== 0 || input_ready !== 1'b0 || dut.state !== IDLE) begin
            errors++; $display("FAIL mid_reset: count=%0d strobe=%b state=%0d expected 0 0 0", fifo_count, input_ready, dut.state);
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL mid_discard: strobe=%b expected 0", input_ready); end
        end
        input_available = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random_stream;
        int busy = 0;
        bit acc, av;
        logic [W-1:0] a, b;
        qa.delete(); qb.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            a = rnd(); b = rnd();
            input_available = (busy == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = a; in_b = b;
            #1;
            checks++;
            if (in_ready !== (qa.size() < DEPTH)) begin
                errors++; $display("FAIL rand_in_ready: got %b expected %b (queued %0d)", in_ready, qa.size() < DEPTH, qa.size());
            end
            acc = in_valid && in_ready;
            av  = input_available;
            tick();
            if (busy > 0) busy--;
            if (input_ready) begin
                checks++;
                if (!av || qa.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: strobe=1 expected 0 (avail=%b queued=%0d)", av, qa.size());
                end else begin
                    checks++;
                    if (gcd_a !== qa[0] || gcd_b !== qb[0]) begin
                        errors++; $display("FAIL rand_order: got %0d/%0d expected %0d/%0d", gcd_a, gcd_b, qa[0], qb[0]);
                    end
                    void'(qa.pop_front()); void'(qb.pop_front());
                end
                busy = $urandom_range(2, 5);
            end
            if (acc) begin qa.push_back(a); qb.push_back(b); end
            checks++;
            if (fifo_count !== qa.size()) begin
                errors++; $display("FAIL rand_count: got %0d expected %0d", fifo_count, qa.size());
            end
        end
        in_valid = 1'b0;
        input_available = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        sys_rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; input_available = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_hold();
        test_same_edge();
        test_zero_pair();
        test_reset_mid();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_operand_feeder.md
GCD_OPERAND_FEEDER -- requirements
Module: gcd_operand_feeder

Interface
- REQ-001: Parameter W, default 16, operand width in bits.
- REQ-002: Parameter DEPTH, default 4, operand-pair FIFO depth; SHALL be a power of two, 2..16.
- REQ-003: sys_clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: sys_rst  input  1  reset, synchronous and active-high.
- REQ-005: in_valid  input  1  upstream pair valid.
- REQ-006: in_ready  output  1  feeder can accept a pair.
- REQ-007: in_a  input  W  first operand.
- REQ-008: in_b  input  W  second operand.
- REQ-009: input_available  input  1  GCD controller is in READY and can load operands.
- REQ-010: input_ready  output  1  one-cycle load strobe to the GCD controller.
- REQ-011: gcd_a  output  W  operand A presented to the GCD datapath.
- REQ-012: gcd_b  output  W  operand B presented to the GCD datapath.
- REQ-013: fifo_count  output  clog2(DEPTH)+1  number of stored pairs.
- REQ-014: drop_cnt  output  8  dropped zero-pair count; present only when ZERO_FILTER_EN is defined.

Function
- REQ-015: A pair SHALL be written on any edge where in_valid and in_ready are both high; in_ready SHALL equal !full and SHALL be independent of pop activity, so there is no write-through when full.
- REQ-016: A push and a pop on the same edge SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
- REQ-017: The FSM SHALL have three states: IDLE, ISSUE and WAIT.
- REQ-018: IDLE->ISSUE SHALL occur when the FIFO is non-empty and input_available=1; on that edge gcd_a/gcd_b SHALL be registered from the FIFO head and the entry popped.
- REQ-019: In ISSUE, input_ready SHALL be high for exactly one cycle, and the state SHALL then move to WAIT unconditionally.
- REQ-020: WAIT->IDLE SHALL occur on the first edge where input_available=0, meaning the controller has left READY.
- REQ-021: gcd_a/gcd_b SHALL hold their values in ISSUE and WAIT, and SHALL change only on an IDLE->ISSUE edge.
- REQ-022: Latency: a pair accepted into an empty FIFO at edge t with input_available=1 SHALL produce input_ready=1 in the cycle after edge t+1.
- REQ-023: input_ready SHALL never be asserted while input_available=0, and SHALL never be asserted twice without an intervening WAIT->IDLE transition.
- REQ-024: When the FIFO is empty in IDLE, the state SHALL remain IDLE and outputs SHALL hold.

Reset
- REQ-025: With sys_rst=1 at an edge: state=IDLE, pointers=0, fifo_count=0, input_ready=0, gcd_a=0, gcd_b=0, drop_cnt=0; in_ready SHALL be 0 while sys_rst is high.
- REQ-026: Reset mid-operation SHALL discard all stored pairs; FIFO storage contents need no reset.

Configuration
- REQ-027: When ZERO_FILTER_EN is defined, a head pair with a=0 and b=0 SHALL be popped in IDLE without entering ISSUE, and drop_cnt SHALL increment, saturating at 255; this pop SHALL not require input_available.
- REQ-028: When ZERO_FILTER_EN is undefined, all pairs SHALL be forwarded unchanged and the drop_cnt port SHALL not exist.

Structure
- REQ-029: A shared package gcd_pkg SHALL hold the state encodings (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10) and the default W/DEPTH constants.
- REQ-030: The FIFO SHALL be a sub-module pair_fifo (parameters W, DEPTH) with push/pop/full/empty/count.

Verification
- REQ-031: Push (48,18) with input_available=1 -> input_ready high for 1 cycle, 2 cycles after acceptance; gcd_a=48, gcd_b=18.
- REQ-032: Push 4 pairs with input_available=0 -> fifo_count=4, in_ready=0; a 5th pair is not accepted; raise input_available -> pairs issued in order.
- REQ-033: input_available held high 3 cycles after the strobe -> no second input_ready until it drops; the second pair is issued only after.
- REQ-034: Push and pop on the same edge at fifo_count=2 -> fifo_count stays 2; pointer wrap over 10 pairs preserves order.
- REQ-035: sys_rst asserted in WAIT with 3 pairs queued -> next cycle fifo_count=0, state IDLE, input_ready=0.
- REQ-036: ZERO_FILTER_EN defined, push (0,0) then (9,6) -> drop_cnt=1, only (9,6) issued; 300 zero pairs -> drop_cnt=255.
